// File: rtl/imem_loader_ctrl_if.sv
// Fetch-read and host-download signal bundle for imem_loader_ctrl.
interface imem_loader_ctrl_if #(
    parameter int IMEMADDRW = 10,
    parameter int INS_W     = 32,
    parameter int HOST_W    = 8
);
    logic                 t_cs;
    logic                 pc_en_b;
    logic [IMEMADDRW-1:0] mv_PC;
    logic [INS_W-1:0]     ins_mem_o;
    logic                 ld_start;
    logic [IMEMADDRW-1:0] ld_base_addr;
    logic [IMEMADDRW:0]   ld_len;
    logic                 ld_valid;
    logic [HOST_W-1:0]    ld_data;
    logic                 ld_ready;
    logic                 ld_busy;
    logic                 ld_done;
    logic                 ld_err;
    logic                 boot_en;
    logic [IMEMADDRW-1:0] boot_addr;
    logic [INS_W-1:0]     ld_chksum;

    modport slave (
        input  t_cs, pc_en_b, mv_PC, ld_start, ld_base_addr, ld_len, ld_valid, ld_data,
        output ins_mem_o, ld_ready, ld_busy, ld_done, ld_err, boot_en, boot_addr, ld_chksum
    );

    modport master (
        output t_cs, pc_en_b, mv_PC, ld_start, ld_base_addr, ld_len, ld_valid, ld_data,
        input  ins_mem_o, ld_ready, ld_busy, ld_done, ld_err, boot_en, boot_addr, ld_chksum
    );
endinterface

// File: rtl/imem_loader_ctrl.sv
// Instruction SRAM with host downloader; fetch read latency 1 cycle, host beats stalled via ld_ready
// (low outside PACK). Optional XOR checksum of loaded words under IMEM_CHKSUM_EN.
module imem_loader_ctrl #(
    parameter int               IMEMADDRW  = 10,
    parameter int               INS_W      = 32,
    parameter int               HOST_W     = 8,
    parameter logic [INS_W-1:0] ALLNOP_VAL = '0
) (
    input logic                clk,
    input logic                reset_b,
    imem_loader_ctrl_if.slave  bus
);
    localparam int BEATS = INS_W / HOST_W;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int DEPTH = 1 << IMEMADDRW;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, PACK, WRITE, DONE} state_t;

    state_t               state_q, state_d;
    logic [BCW-1:0]       beat_q, beat_d;
    logic [IMEMADDRW:0]   word_q, word_d;
    logic [IMEMADDRW:0]   len_q, len_d;
    logic [IMEMADDRW-1:0] wr_addr_q, wr_addr_d;
    logic [IMEMADDRW-1:0] base_q, base_d;
    logic [INS_W-1:0]     pack_q, pack_d;
    logic                 err_q, err_d;
    logic [INS_W-1:0]     ins_q;
    logic [INS_W-1:0]     mem [DEPTH];
    logic                 busy;

    assign busy = (state_q == PACK) || (state_q == WRITE);

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        word_d    = word_q;
        len_d     = len_q;
        wr_addr_d = wr_addr_q;
        base_d    = base_q;
        pack_d    = pack_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (bus.ld_start) begin
                    base_d    = bus.ld_base_addr;
                    wr_addr_d = bus.ld_base_addr;
                    len_d     = bus.ld_len;
                    word_d    = '0;
                    beat_d    = '0;
                    err_d     = 1'b0;
                    state_d   = (bus.ld_len == '0) ? DONE : PACK;
                end
            end
            PACK: begin
                // ld_ready is high throughout PACK, so valid alone means accepted
                if (bus.ld_valid) begin
                    pack_d[int'(beat_q) * HOST_W +: HOST_W] = bus.ld_data;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = WRITE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                wr_addr_d = wr_addr_q + 1'b1;
                word_d    = word_q + 1'b1;
                if (&wr_addr_q) begin
                    err_d = 1'b1;
                end
                state_d = (word_d == len_q) ? DONE : PACK;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            beat_q    <= '0;
            word_q    <= '0;
            len_q     <= '0;
            wr_addr_q <= '0;
            base_q    <= '0;
            pack_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            beat_q    <= beat_d;
            word_q    <= word_d;
            len_q     <= len_d;
            wr_addr_q <= wr_addr_d;
            base_q    <= base_d;
            pack_q    <= pack_d;
            err_q     <= err_d;
        end
    end

    // Array has no reset so downloaded code survives a core reset
    always_ff @(posedge clk) begin
        if (state_q == WRITE) begin
            mem[wr_addr_q] <= pack_q;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            ins_q <= ALLNOP_VAL;
        end else if (busy) begin
            ins_q <= ALLNOP_VAL;
        end else if (bus.t_cs && !bus.pc_en_b) begin
            ins_q <= mem[bus.mv_PC];
        end
    end

`ifdef IMEM_CHKSUM_EN
    logic [INS_W-1:0] chksum_q;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            chksum_q <= '0;
        end else if (state_q == IDLE && bus.ld_start) begin
            chksum_q <= '0;
        end else if (state_q == WRITE) begin
            chksum_q <= chksum_q ^ pack_q;
        end
    end

    assign bus.ld_chksum = chksum_q;
`else
    assign bus.ld_chksum = '0;
`endif

    assign bus.ins_mem_o = ins_q;
    assign bus.ld_ready  = (state_q == PACK);
    assign bus.ld_busy   = busy;
    assign bus.ld_done   = (state_q == DONE);
    assign bus.boot_en   = (state_q == DONE);
    assign bus.boot_addr = base_q;
    assign bus.ld_err    = err_q;
endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Scoreboard bench for imem_loader_ctrl: stimulus queues expected reads/completions, a negedge monitor checks them.
module tb_imem_loader_ctrl;
`ifdef IMEM_CHKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic [31:0] v;
    } rd_rec_t;

    typedef struct {
        int          cyc;
        logic [9:0]  addr;
        logic        err;
        logic [31:0] cs;
    } done_rec_t;

    logic clk = 1'b0;
    logic reset_b = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;

    rd_rec_t     rd_q[$];
    done_rec_t   done_q[$];
    logic [7:0]  beats_q[$];
    logic [31:0] mdl [int];

    imem_loader_ctrl_if #(.IMEMADDRW(10), .INS_W(32), .HOST_W(8)) bif ();

    imem_loader_ctrl #(.IMEMADDRW(10), .INS_W(32), .HOST_W(8), .ALLNOP_VAL(32'h0)) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (bif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations when the DUT presents data
    always @(negedge clk) begin
        rd_rec_t   r;
        done_rec_t d;
        while (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
            r = rd_q.pop_front();
            chk("ins_mem_o", {32'h0, bif.ins_mem_o}, {32'h0, r.v});
        end
        chk("boot_en_eq_ld_done", {63'h0, bif.boot_en}, {63'h0, bif.ld_done});
        if (bif.ld_done) begin
            if (done_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ld_done: got 1 required 0 (cycle %0d)", cyc);
            end else begin
                d = done_q.pop_front();
                chk("boot_addr", {54'h0, bif.boot_addr}, {54'h0, d.addr});
                chk("ld_err_at_done", {63'h0, bif.ld_err}, {63'h0, d.err});
                chk("ld_chksum", {32'h0, bif.ld_chksum}, {32'h0, d.cs});
                chk("ld_busy_at_done", {63'h0, bif.ld_busy}, 64'h0);
                if (d.cyc >= 0) chk("done_cycle", 64'(cyc), 64'(d.cyc));
                done_cnt++;
            end
        end
    end

    task automatic rd(input logic [9:0] a);
        rd_rec_t r;
        bif.t_cs    = 1'b1;
        bif.pc_en_b = 1'b0;
        bif.mv_PC   = a;
        r.cyc = cyc + 1;
        r.v   = mdl[int'(a)];
        rd_q.push_back(r);
        @(posedge clk); #1;
    endtask

    task automatic load(input logic [9:0] base, input int len, input bit toggle, input bit chk_ins);
        done_rec_t   d;
        logic [31:0] w;
        logic [31:0] cs;
        int          target;
        int          i;
        int          budget;
        bit          v;
        bit          acc;
        cs = 32'h0;
        for (int k = 0; k < len; k++) begin
            w = {beats_q[4*k+3], beats_q[4*k+2], beats_q[4*k+1], beats_q[4*k]};
            mdl[(int'(base) + k) & 32'h3FF] = w;
            cs ^= w;
        end
        d.addr = base;
        d.err  = (len > 0) && (int'(base) + len >= 1024);
        d.cs   = CS_EN ? cs : 32'h0;
        d.cyc  = (len == 0) ? cyc + 1 : -1;
        done_q.push_back(d);
        target = done_cnt + 1;

        bif.ld_start     = 1'b1;
        bif.ld_base_addr = base;
        bif.ld_len       = 11'(len);
        @(posedge clk); #1;
        bif.ld_start = 1'b0;
        chk("ld_err_cleared_on_start", {63'h0, bif.ld_err}, 64'h0);

        i = 0;
        budget = 0;
        v = 1'b1;
        while (i < beats_q.size() && budget < 400) begin
            bif.ld_valid = toggle ? v : 1'b1;
            bif.ld_data  = beats_q[i];
            v   = !v;
            acc = bif.ld_valid && bif.ld_ready;
            @(posedge clk); #1;
            budget++;
            if (chk_ins) chk("ins_allnop_while_busy", {32'h0, bif.ins_mem_o}, 64'h0);
            if (acc) begin
                i++;
                if (i % 4 == 0) begin
                    chk("ld_ready_in_write", {63'h0, bif.ld_ready}, 64'h0);
                    chk("ld_busy_in_write", {63'h0, bif.ld_busy}, 64'h1);
                end
            end
        end
        bif.ld_valid = 1'b0;
        chk("beats_accepted", 64'(i), 64'(beats_q.size()));

        budget = 0;
        while (done_cnt < target && budget < 64) begin
            @(posedge clk); #1;
            budget++;
        end
        chk("ld_done_seen", {63'h0, done_cnt >= target}, 64'h1);
        beats_q.delete();
    endtask

    task automatic reset_state_checks(input string tag);
        chk({tag, "_ins_mem_o"}, {32'h0, bif.ins_mem_o}, 64'h0);
        chk({tag, "_ld_ready"}, {63'h0, bif.ld_ready}, 64'h0);
        chk({tag, "_ld_busy"}, {63'h0, bif.ld_busy}, 64'h0);
        chk({tag, "_ld_done"}, {63'h0, bif.ld_done}, 64'h0);
        chk({tag, "_boot_en"}, {63'h0, bif.boot_en}, 64'h0);
        chk({tag, "_ld_err"}, {63'h0, bif.ld_err}, 64'h0);
        chk({tag, "_boot_addr"}, {54'h0, bif.boot_addr}, 64'h0);
        chk({tag, "_ld_chksum"}, {32'h0, bif.ld_chksum}, 64'h0);
    endtask

    initial begin
        bif.t_cs = 1'b0;  bif.pc_en_b = 1'b1;  bif.mv_PC = '0;
        bif.ld_start = 1'b0;  bif.ld_base_addr = '0;  bif.ld_len = '0;
        bif.ld_valid = 1'b0;  bif.ld_data = '0;

        // 1: reset values
        #12;
        reset_state_checks("reset");
        @(posedge clk); #1;
        reset_b = 1'b1;
        @(posedge clk); #1;

        // 2: basic two-word download
        beats_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        load(10'h010, 2, 1'b0, 1'b0);

        // 3: fetch reads, then hold with t_cs low and with pc_en_b high
        rd(10'h010);
        rd(10'h011);
        bif.t_cs = 1'b0;
        bif.pc_en_b = 1'b0;
        bif.mv_PC = 10'h010;
        rd_q.push_back('{cyc + 1, 32'h88776655});
        rd_q.push_back('{cyc + 2, 32'h88776655});
        repeat (2) begin @(posedge clk); #1; end
        bif.t_cs = 1'b1;
        bif.pc_en_b = 1'b1;
        rd_q.push_back('{cyc + 1, 32'h88776655});
        @(posedge clk); #1;

        // 4: gapped valid, fetch enabled during load
        bif.t_cs = 1'b1;
        bif.pc_en_b = 1'b0;
        bif.mv_PC = 10'h010;
        @(posedge clk); #1;
        beats_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};
        load(10'h030, 2, 1'b1, 1'b1);
        rd(10'h030);
        rd(10'h031);
        bif.pc_en_b = 1'b1;

        // 5: address wrap sets ld_err, next start clears it
        beats_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        load(10'h3FF, 2, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("ld_err_sticky", {63'h0, bif.ld_err}, 64'h1);
        rd(10'h3FF);
        rd(10'h000);
        bif.pc_en_b = 1'b1;
        beats_q = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
        load(10'h050, 1, 1'b0, 1'b0);
        rd(10'h050);
        bif.pc_en_b = 1'b1;

        // 6: zero-length load leaves the array untouched
        load(10'h010, 0, 1'b0, 1'b0);
        rd(10'h010);
        rd(10'h011);
        bif.pc_en_b = 1'b1;

        // 6b: reset in mid-PACK, then a fresh load
        bif.ld_start = 1'b1;
        bif.ld_base_addr = 10'h100;
        bif.ld_len = 11'd1;
        @(posedge clk); #1;
        bif.ld_start = 1'b0;
        bif.ld_valid = 1'b1;
        bif.ld_data = 8'h55;
        repeat (2) begin @(posedge clk); #1; end
        chk("mid_pack_busy", {63'h0, bif.ld_busy}, 64'h1);
        bif.ld_valid = 1'b0;
        reset_b = 1'b0;
        #1;
        reset_state_checks("midreset");
        @(posedge clk); #1;
        reset_b = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_idle_ready", {63'h0, bif.ld_ready}, 64'h0);
        beats_q = '{8'h0D, 8'hF0, 8'hAD, 8'hDE};
        load(10'h020, 1, 1'b0, 1'b0);
        rd(10'h020);
        rd(10'h030);
        bif.pc_en_b = 1'b1;

        repeat (3) begin @(posedge clk); #1; end
        chk("queues_drained", 64'(rd_q.size() + done_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
